// File: rtl/btn_pkg.sv
// Shared definitions for the button front end: gesture FSM states, default
// gesture periods at 100 kHz and the active press level used by the debouncer.
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        WAIT2  = 3'd2,
        PRESS2 = 3'd3,
        HELD   = 3'd4
    } btn_state_t;

    localparam int   BTN_LONG_PRDS   = 100000;
    localparam int   BTN_DBL_PRDS    = 30000;
    localparam int   BTN_REPEAT_PRDS = 20000;
    localparam logic BTN_PRESS_LEVEL = 1'b1;

endpackage

// File: rtl/gesture_period_counter.sv
// Clearable up-counter with an equality terminal-count flag; the gesture FSM
// shares one instance across all of its timed states.
module gesture_period_counter #(
    parameter int CNTWIDTH = 17
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                enable,
    input  logic [CNTWIDTH-1:0] limit,
    output logic                done
);

    logic [CNTWIDTH-1:0] cnt_q;
    logic [CNTWIDTH-1:0] cnt_d;

    // Clear has priority over counting so a state entry always starts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = {CNTWIDTH{1'b0}};
        end else if (enable) begin
            cnt_d = cnt_q + {{(CNTWIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= {CNTWIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == limit);

endmodule

// File: rtl/button_gesture_decoder.sv
// Decodes debounced press/release pulses into short, long, double-click and
// auto-repeat gestures. Auto-repeat is built only when BTN_REPEAT_EN is defined.
module button_gesture_decoder
    import btn_pkg::*;
#(
    parameter int LONG_PRDS   = BTN_LONG_PRDS,
    parameter int DBL_PRDS    = BTN_DBL_PRDS,
    parameter int REPEAT_PRDS = BTN_REPEAT_PRDS,
    parameter int CNTWIDTH    = 17
) (
    input  logic clk_100K,
    input  logic rst_n,
    input  logic btnPress,
    input  logic btnRelease,
    output logic shortPress,
    output logic longPress,
    output logic doubleClick,
    output logic repeatPulse,
    output logic busy
);

    btn_state_t          state_q, state_d;
    logic                short_press_q, short_press_d;
    logic                long_press_q, long_press_d;
    logic                double_click_q, double_click_d;
    logic                repeat_pulse_q, repeat_pulse_d;
    logic                busy_q, busy_d;
    logic                press_ev, release_ev;
    logic                cnt_clear, cnt_en, cnt_done;
    logic [CNTWIDTH-1:0] cnt_limit;

    // A simultaneous press and release cancel each other out.
    assign press_ev   = btnPress & ~btnRelease;
    assign release_ev = btnRelease & ~btnPress;

    gesture_period_counter #(
        .CNTWIDTH (CNTWIDTH)
    ) u_period_cnt (
        .clk    (clk_100K),
        .rst_n  (rst_n),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .limit  (cnt_limit),
        .done   (cnt_done)
    );

    // Terminal count for whichever timed state is active.
    always_comb begin
        case (state_q)
            PRESS1:  cnt_limit = CNTWIDTH'(LONG_PRDS - 1);
            WAIT2:   cnt_limit = CNTWIDTH'(DBL_PRDS - 1);
            HELD:    cnt_limit = CNTWIDTH'(REPEAT_PRDS - 1);
            default: cnt_limit = {CNTWIDTH{1'b1}};
        endcase
    end

    // State register plus the registered gesture outputs.
    always_ff @(posedge clk_100K) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            short_press_q  <= 1'b0;
            long_press_q   <= 1'b0;
            double_click_q <= 1'b0;
            repeat_pulse_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            short_press_q  <= short_press_d;
            long_press_q   <= long_press_d;
            double_click_q <= double_click_d;
            repeat_pulse_q <= repeat_pulse_d;
            busy_q         <= busy_d;
        end
    end

    // Next state; user events take priority over terminal counts on the same edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (press_ev) state_d = PRESS1;
                else          state_d = IDLE;
            end
            PRESS1: begin
                if (release_ev)    state_d = WAIT2;
                else if (cnt_done) state_d = HELD;
                else               state_d = PRESS1;
            end
            WAIT2: begin
                if (press_ev)      state_d = PRESS2;
                else if (cnt_done) state_d = IDLE;
                else               state_d = WAIT2;
            end
            PRESS2: begin
                if (release_ev) state_d = IDLE;
                else            state_d = PRESS2;
            end
            HELD: begin
                if (release_ev) state_d = IDLE;
                else            state_d = HELD;
            end
            default: state_d = IDLE;
        endcase
    end

    // Gesture decisions and counter control.
    always_comb begin
        short_press_d  = (state_q == WAIT2)  && !press_ev   && cnt_done;
        long_press_d   = (state_q == PRESS1) && !release_ev && cnt_done;
        double_click_d = (state_q == WAIT2)  && press_ev;
        busy_d         = (state_d != IDLE);
`ifdef BTN_REPEAT_EN
        repeat_pulse_d = (state_q == HELD) && !release_ev && cnt_done;
        cnt_en         = (state_q == PRESS1) || (state_q == WAIT2) || (state_q == HELD);
`else
        repeat_pulse_d = 1'b0;
        cnt_en         = (state_q == PRESS1) || (state_q == WAIT2);
`endif
        // Restarting on each repeat keeps HELD periodic without a second counter.
        cnt_clear = (state_d != state_q) || repeat_pulse_d;
    end

    assign shortPress  = short_press_q;
    assign longPress   = long_press_q;
    assign doubleClick = double_click_q;
    assign repeatPulse = repeat_pulse_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Self-checking bench: directed gesture scenarios followed by random event
// traffic, all checked against a timestamp-based gesture model.
module tb_button_gesture_decoder;

    localparam int LONG = 20;
    localparam int DBL  = 10;
    localparam int REP  = 5;
`ifdef BTN_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n, btn_press, btn_release;
    logic short_press, long_press, double_click, repeat_pulse, busy;

    int checks = 0;
    int errors = 0;

    // Model: phase 0 idle, 1 first hold, 2 window open, 3 second hold, 4 long hold.
    int edge_no = 0;
    int phase   = 0;
    int t_mark  = 0;
    int c_short, c_long, c_dbl, c_rep;

    button_gesture_decoder #(
        .LONG_PRDS   (LONG),
        .DBL_PRDS    (DBL),
        .REPEAT_PRDS (REP),
        .CNTWIDTH    (17)
    ) dut (
        .clk_100K    (clk),
        .rst_n       (rst_n),
        .btnPress    (btn_press),
        .btnRelease  (btn_release),
        .shortPress  (short_press),
        .longPress   (long_press),
        .doubleClick (double_click),
        .repeatPulse (repeat_pulse),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at edge %0d observed %b expected %b", tag, edge_no, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        c_short = 0; c_long = 0; c_dbl = 0; c_rep = 0;
    endtask

    task automatic step(input logic rst, input logic p, input logic r);
        logic e_short, e_long, e_dbl, e_rep;
        logic pe, re;
        rst_n       = rst;
        btn_press   = p;
        btn_release = r;
        @(posedge clk);
        #1;
        edge_no++;
        e_short = 1'b0; e_long = 1'b0; e_dbl = 1'b0; e_rep = 1'b0;
        pe = p && !r;
        re = r && !p;
        if (!rst) begin
            phase = 0;
        end else begin
            case (phase)
                0: if (pe) begin phase = 1; t_mark = edge_no; end
                1: if (re) begin phase = 2; t_mark = edge_no; end
                   else if (edge_no - t_mark == LONG) begin
                       e_long = 1'b1; phase = 4; t_mark = edge_no;
                   end
                2: if (pe) begin e_dbl = 1'b1; phase = 3; end
                   else if (edge_no - t_mark == DBL) begin e_short = 1'b1; phase = 0; end
                3: if (re) phase = 0;
                4: if (re) phase = 0;
                   else if (REP_EN && ((edge_no - t_mark) % REP == 0)) e_rep = 1'b1;
                default: phase = 0;
            endcase
        end
        check_bit("shortPress",  short_press,  e_short);
        check_bit("longPress",   long_press,   e_long);
        check_bit("doubleClick", double_click, e_dbl);
        check_bit("repeatPulse", repeat_pulse, e_rep);
        check_bit("busy",        busy,         logic'(phase != 0));
        c_short += int'(short_press);
        c_long  += int'(long_press);
        c_dbl   += int'(double_click);
        c_rep   += int'(repeat_pulse);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; btn_press = 1'b0; btn_release = 1'b0;
        clear_counts();

        // Reset state
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check_bit("reset_busy", busy, 1'b0);
        idle(3);

        // Short press: release 5 edges after press, shortPress 10 edges later
        clear_counts();
        step(1'b1, 1'b1, 1'b0);
        idle(4);
        step(1'b1, 1'b0, 1'b1);
        idle(12);
        check_int("short_cnt", c_short, 1);
        check_int("short_other", c_long + c_dbl + c_rep, 0);

        // Double click
        clear_counts();
        step(1'b1, 1'b1, 1'b0);
        idle(2);
        step(1'b1, 1'b0, 1'b1);
        idle(4);
        step(1'b1, 1'b1, 1'b0);
        idle(3);
        step(1'b1, 1'b0, 1'b1);
        idle(12);
        check_int("dbl_cnt", c_dbl, 1);
        check_int("dbl_short", c_short, 0);

        // Long press held 40 clocks
        clear_counts();
        step(1'b1, 1'b1, 1'b0);
        idle(40);
        step(1'b1, 1'b0, 1'b1);
        idle(3);
        check_int("long_cnt", c_long, 1);
        check_int("long_rep", c_rep, REP_EN ? 4 : 0);
        check_int("long_short", c_short, 0);

        // Release on the long terminal edge
        clear_counts();
        step(1'b1, 1'b1, 1'b0);
        idle(19);
        step(1'b1, 1'b0, 1'b1);
        idle(12);
        check_int("race_long", c_long, 0);
        check_int("race_short", c_short, 1);

        // Second press on the window-expiry edge
        clear_counts();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        idle(9);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        idle(12);
        check_int("expiry_dbl", c_dbl, 1);
        check_int("expiry_short", c_short, 0);

        // Same-cycle events and stray release in IDLE
        step(1'b1, 1'b1, 1'b1);
        check_bit("both_idle_busy", busy, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check_bit("stray_rel_busy", busy, 1'b0);
        idle(2);

        // Reset mid-press at cnt=15
        clear_counts();
        step(1'b1, 1'b1, 1'b0);
        idle(15);
        step(1'b0, 1'b0, 1'b0);
        check_bit("rst_mid_busy", busy, 1'b0);
        idle(30);
        check_int("rst_mid_long", c_long, 0);

        // Random event traffic
        for (int i = 0; i < 4000; i++) begin
            int sel;
            sel = int'($urandom_range(0, 199));
            if (sel == 0)       step(1'b0, 1'b0, 1'b0);
            else if (sel < 9)   step(1'b1, 1'b1, 1'b0);
            else if (sel < 17)  step(1'b1, 1'b0, 1'b1);
            else if (sel == 17) step(1'b1, 1'b1, 1'b1);
            else                step(1'b1, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
